// File: rtl/freq_gate_pkg.sv
// Shared definitions for the frequency-meter gate sequencer.
// Register map, CTRL/STATUS bit positions and FSM states.
package freq_gate_pkg;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_GLEN = 2'd1;
  localparam logic [1:0] A_RES  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  localparam int C_START = 0;
  localparam int C_CONT  = 1;
  localparam int C_IRQEN = 2;

  localparam int S_DONE = 0;
  localparam int S_BUSY = 1;
  localparam int S_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/freq_gate_ctrl_edge_sync_det.sv
// Synchroniser for the asynchronous measured signal
// plus a one-cycle rising-edge pulse.
module edge_sync_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate sequencer, edge counter and Avalon-MM registers.
// Optional: FREQ_GATE_OVF_EN enables edge-count saturation and STATUS.OVF.
module freq_gate_ctrl
  import freq_gate_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int GATE_DEF    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        sig_in,
  output logic        gate_en
);

  state_t              r_state;
  state_t              w_next;
  logic                r_cont;
  logic                r_irq_en;
  logic [GATE_W-1:0]   r_gate_len;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic [CNT_W-1:0]    r_result;
  logic                r_done;
  logic [31:0]         r_readdata;

  logic                w_wr;
  logic                w_rd;
  logic                w_start;
  logic                w_stat_wr;
  logic                w_glen_nz;
  logic                w_load;
  logic                w_rise;
  logic                w_ovf;
  logic [CNT_W-1:0]    w_edge_nxt;
  logic [31:0]         w_rdata;

  edge_sync_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_sig  (sig_in),
    .o_rise (w_rise)
  );

  assign w_wr      = chipselect & ~write_n;
  assign w_rd      = chipselect & write_n;
  assign w_start   = w_wr && (address == A_CTRL)
                     && writedata[C_START];
  assign w_stat_wr = w_wr && (address == A_STAT);
  assign w_glen_nz = |r_gate_len;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start && w_glen_nz) begin
          w_next = ST_GATE;
          w_load = 1'b1;
        end
      end
      ST_GATE: begin
        if (r_gate_cnt == GATE_W'(1)) w_next = ST_LATCH;
      end
      ST_LATCH: begin
        if (r_cont && w_glen_nz) begin
          w_next = ST_GATE;
          w_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

`ifdef FREQ_GATE_OVF_EN
  logic w_sat;
  logic r_ovf;

  assign w_sat      = &r_edge_cnt;
  assign w_edge_nxt = (w_rise && !w_sat) ?
                      r_edge_cnt + CNT_W'(1) : r_edge_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_ovf <= 1'b0;
    else if (r_state == ST_GATE && w_rise && w_sat)
      r_ovf <= 1'b1;
    else if (w_load || w_stat_wr)
      r_ovf <= 1'b0;
  end

  assign w_ovf = r_ovf;
`else
  assign w_edge_nxt = r_edge_cnt + CNT_W'(w_rise);
  assign w_ovf      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
    end else if (w_load) begin
      r_gate_cnt <= r_gate_len;
      r_edge_cnt <= '0;
    end else if (r_state == ST_GATE) begin
      r_gate_cnt <= r_gate_cnt - GATE_W'(1);
      r_edge_cnt <= w_edge_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cont     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_gate_len <= GATE_W'(GATE_DEF);
    end else if (w_wr) begin
      if (address == A_CTRL) begin
        r_cont   <= writedata[C_CONT];
        r_irq_en <= writedata[C_IRQEN];
      end
      if (address == A_GLEN)
        r_gate_len <= writedata[GATE_W-1:0];
    end
  end

  // LATCH wins over a simultaneous STATUS clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (r_state == ST_LATCH) begin
      r_result <= r_edge_cnt;
      r_done   <= 1'b1;
    end else if (w_stat_wr) begin
      r_done   <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (address)
      A_CTRL: begin
        w_rdata[C_CONT]  = r_cont;
        w_rdata[C_IRQEN] = r_irq_en;
      end
      A_GLEN: w_rdata[GATE_W-1:0] = r_gate_len;
      A_RES:  w_rdata[CNT_W-1:0]  = r_result;
      A_STAT: begin
        w_rdata[S_DONE] = r_done;
        w_rdata[S_BUSY] = (r_state != ST_IDLE);
        w_rdata[S_OVF]  = w_ovf;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd ? w_rdata : '0;
  end

  assign readdata = r_readdata;
  assign irq      = r_done & r_irq_en;
  assign gate_en  = (r_state == ST_GATE);

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl (CNT_W=8 build).
// Expected counts come from a sampled history of sig_in.
module tb_freq_gate_ctrl;
  import freq_gate_pkg::*;

  localparam int CW  = 8;
  localparam int SS  = 2;
  localparam int GD  = 50_000_000;
  localparam int HN  = 16384;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        sig_in;
  logic        gate_en;

  freq_gate_ctrl #(
    .CNT_W(CW), .GATE_W(32),
    .GATE_DEF(GD), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq),
    .sig_in(sig_in), .gate_en(gate_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hi_cnt = 0;
  int last_w = 0;
  int mode = 0;
  int per = 10;
  bit g_prev = 1'b0;
  bit sig_hist [HN];
  int rises [$];

  // sig_in value sampled at posedge cyc+1
  always @(negedge clk) begin
    unique case (mode)
      1: sig_in = ((cyc + 1) % per) < (per / 2);
      2: sig_in = 1'($urandom);
      3: sig_in = 1'((cyc + 1) % 2);
      default: sig_in = 1'b0;
    endcase
    if (cyc + 1 < HN) sig_hist[cyc + 1] = sig_in;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (gate_en) begin
      hi_cnt++;
      if (!g_prev) rises.push_back(cyc);
    end
    g_prev = gate_en;
  end

  // Rising edges reach the counter SS cycles late;
  // window covers the L cycles after the START edge.
  function automatic int count_edges(int w, int l);
    int n = 0;
    for (int m = w - SS + 1; m <= w + l - SS; m++)
      if (sig_hist[m] && !sig_hist[m - 1]) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_res(int n);
`ifdef FREQ_GATE_OVF_EN
    return (n > 255) ? 32'd255 : 32'(n);
`else
    return 32'(n % 256);
`endif
  endfunction

  function automatic logic exp_ovf(int n);
`ifdef FREQ_GATE_OVF_EN
    return n > 255;
`else
    return (n < 0);
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    last_w     = cyc + 1;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [31:0] d;
    int w, l, n, prev_res;

    vt[0]  = '{0, A_CTRL, 32'h0, 32'h0};
    vt[1]  = '{0, A_GLEN, 32'h0, 32'(GD)};
    vt[2]  = '{0, A_RES,  32'h0, 32'h0};
    vt[3]  = '{0, A_STAT, 32'h0, 32'h0};
    vt[4]  = '{1, A_GLEN, 32'hFFFF_FFFF, 32'h0};
    vt[5]  = '{0, A_GLEN, 32'h0, 32'hFFFF_FFFF};
    vt[6]  = '{1, A_CTRL, 32'hFFFF_FFF6, 32'h0};
    vt[7]  = '{0, A_CTRL, 32'h0, 32'h6};
    vt[8]  = '{1, A_CTRL, 32'h0, 32'h0};
    vt[9]  = '{0, A_CTRL, 32'h0, 32'h0};
    vt[10] = '{1, A_RES,  32'hDEAD, 32'h0};
    vt[11] = '{1, A_GLEN, 32'h0, 32'h0};
    vt[12] = '{1, A_CTRL, 32'h1, 32'h0};
    vt[13] = '{0, A_STAT, 32'h0, 32'h0};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0;
    #1;
    chk("rst_gate_en", 32'(gate_en), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_readdata", readdata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) wr(vt[i].a, vt[i].d);
      else begin
        rd(vt[i].a, d);
        chk($sformatf("vec%0d", i), d, vt[i].exp);
      end
    end
    rd(A_RES, d);
    chk("ro_result", d, 0);

    // basic 100-cycle gate, 10-cycle signal period
    mode = 1; per = 10;
    wr(A_GLEN, 100);
    hi_cnt = 0;
    wr(A_CTRL, 1);
    w = last_w;
    repeat (110) @(negedge clk);
    chk("A_gate_cycles", hi_cnt, 100);
    rd(A_RES, d);
    chk("A_result", d, 10);
    chk("A_result_model", d, exp_res(count_edges(w, 100)));
    rd(A_STAT, d);
    chk("A_status", d, 1);
    chk("A_irq_off", 32'(irq), 0);
    wr(A_CTRL, 4);
    chk("A_irq_on", 32'(irq), 1);
    wr(A_STAT, 0);
    chk("A_irq_clr", 32'(irq), 0);
    rd(A_STAT, d);
    chk("A_status_clr", d, 0);

    // START while busy, GATE_LEN write while busy
    mode = 2;
    wr(A_GLEN, 40);
    hi_cnt = 0;
    wr(A_CTRL, 1);
    w = last_w;
    repeat (10) @(negedge clk);
    wr(A_CTRL, 1);
    wr(A_GLEN, 7);
    repeat (40) @(negedge clk);
    chk("B_gate_cycles", hi_cnt, 40);
    rd(A_RES, d);
    prev_res = int'(d);
    chk("B_result", d, exp_res(count_edges(w, 40)));
    rd(A_GLEN, d);
    chk("B_glen", d, 7);
    wr(A_GLEN, 0);
    wr(A_STAT, 0);
    wr(A_CTRL, 1);
    repeat (5) @(negedge clk);
    rd(A_STAT, d);
    chk("B_zero_len_status", d, 0);
    rd(A_RES, d);
    chk("B_zero_len_result", d, 32'(prev_res));
    chk("B_zero_len_gate", hi_cnt, 40);

    // continuous mode, CONT cleared inside 4th window
    mode = 1; per = 4;
    wr(A_GLEN, 20);
    rises.delete();
    hi_cnt = 0;
    wr(A_CTRL, 3);
    w = last_w;
    while (cyc < w + 67) @(negedge clk);
    wr(A_CTRL, 0);
    while (cyc < w + 100) @(negedge clk);
    chk("C_windows", rises.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < rises.size())
        chk($sformatf("C_rise%0d", k),
            rises[k], w + 21 * k);
    chk("C_gate_cycles", hi_cnt, 80);
    rd(A_RES, d);
    chk("C_result", d, exp_res(count_edges(w + 63, 20)));
    rd(A_STAT, d);
    chk("C_status", d, 1);

    // STATUS write in the LATCH cycle
    wr(A_STAT, 0);
    wr(A_GLEN, 10);
    wr(A_CTRL, 5);
    w = last_w;
    while (cyc < w + 10) @(negedge clk);
    wr(A_STAT, 0);
    rd(A_STAT, d);
    chk("D_done_kept", d, 1);
    chk("D_irq", 32'(irq), 1);
    wr(A_STAT, 0);
    rd(A_STAT, d);
    chk("D_done_clr", d, 0);
    chk("D_irq_clr", 32'(irq), 0);

    // random lengths, random signal
    mode = 2;
    for (int it = 0; it < 10; it++) begin
      l = $urandom_range(1, 60);
      wr(A_GLEN, 32'(l));
      wr(A_STAT, 0);
      hi_cnt = 0;
      wr(A_CTRL, 1);
      w = last_w;
      repeat (l + 6) @(negedge clk);
      chk($sformatf("R%0d_gate", it), hi_cnt, l);
      rd(A_RES, d);
      chk($sformatf("R%0d_result", it), d,
          exp_res(count_edges(w, l)));
      rd(A_STAT, d);
      chk($sformatf("R%0d_status", it), d, 1);
    end

    // edge count beyond CNT_W range
    mode = 3;
    wr(A_STAT, 0);
    wr(A_GLEN, 600);
    wr(A_CTRL, 1);
    w = last_w;
    repeat (610) @(negedge clk);
    n = count_edges(w, 600);
    rd(A_RES, d);
    chk("O_result", d, exp_res(n));
    rd(A_STAT, d);
    chk("O_status", d, {29'd0, exp_ovf(n), 2'b01});
    wr(A_GLEN, 5);
    wr(A_CTRL, 1);
    w = last_w;
    repeat (12) @(negedge clk);
    rd(A_STAT, d);
    chk("O_ovf_reload", d, 1);
    rd(A_RES, d);
    chk("O_small", d, exp_res(count_edges(w, 5)));

    // reset in the middle of a gate
    mode = 1; per = 10;
    wr(A_GLEN, 1000);
    wr(A_CTRL, 7);
    repeat (50) @(negedge clk);
    chk("E_gate_before", 32'(gate_en), 1);
    reset_n = 1'b0;
    #1;
    chk("E_gate_async", 32'(gate_en), 0);
    chk("E_irq", 32'(irq), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(A_CTRL, d);
    chk("E_ctrl", d, 0);
    rd(A_GLEN, d);
    chk("E_glen", d, 32'(GD));
    rd(A_RES, d);
    chk("E_result", d, 0);
    rd(A_STAT, d);
    chk("E_status", d, 0);
    chk("E_gate_after", 32'(gate_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
